operand_forward_stage: RTL
==========================

// Module: operand_forward_stage
// PURPOSE
//  ID->EX operand stage directly downstream of the 64-bit register file. Takes raw ReadData1/2,
//  resolves RAW hazards by bypassing from EX, MEM and WB. Detects load-use hazards and stalls ID.
//  Registers resolved operands plus control into the ID/EX pipeline register feeding the ALU.
// PARAMETERS
//  DATA_W    64  operand / result width
//  ADDR_W    5   register address width
//  CTRL_W    16  opaque decoded-control bundle width, passed through unchanged
//  ZERO_REG  31  register index hard-wired to zero (XZR); never forwarded, never hazards
// PORTS
//  clk            in   1       system clock, all state updates on posedge
//  reset          in   1       synchronous, active-high
//  id_valid       in   1       ID holds a real instruction
//  id_rn, id_rm   in   ADDR_W  source addresses (same values driven to regfile ReadRegister1/2)
//  id_use_rn/rm   in   1       instruction actually reads rn / rm
//  id_rn_data     in   DATA_W  regfile ReadData1
//  id_rm_data     in   DATA_W  regfile ReadData2
//  id_rd          in   ADDR_W  destination address
//  id_ctrl        in   CTRL_W  decoded control
//  ex_valid, ex_regwrite, ex_memread  in  1   instr now in EX
//  ex_rd          in   ADDR_W  EX destination
//  ex_result      in   DATA_W  EX ALU result (combinational, same cycle)
//  mem_valid, mem_regwrite  in  1           instr now in MEM
//  mem_rd         in   ADDR_W  MEM destination
//  mem_result     in   DATA_W  MEM writeback value (load data for loads)
//  wb_regwrite    in   1       regfile RegWrite this cycle
//  wb_rd          in   ADDR_W  regfile WriteRegister
//  wb_data        in   DATA_W  regfile WriteData
//  flush          in   1       branch taken: kill instruction entering EX
//  ex_hold        in   1       EX cannot accept: freeze ID/EX register
//  stall          out  1       combinational: hold PC and IF/ID this cycle
//  idex_valid     out  1       registered
//  idex_op_a/b    out  DATA_W  registered resolved operands for rn / rm
//  idex_rd        out  ADDR_W  registered
//  idex_ctrl      out  CTRL_W  registered
//  stall_cycles   out  32      saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset: idex_valid=0; op_a/op_b/rd/ctrl=0; stall_cycles=0. stall is 0 while reset is high.
//  Operand select, per source s in {rn, rm}, first match wins:
//   1. s==ZERO_REG -> 0. The regfile value is ignored.
//   2. ex_valid & ex_regwrite & ex_rd==s & !ex_memread -> ex_result.
//   3. mem_valid & mem_regwrite & mem_rd==s -> mem_result.
//   4. wb_regwrite & wb_rd==s -> wb_data. Bypasses the regfile write-before-read gap: the write lands on the same edge.
//   5. Otherwise the regfile data.
//  Load-use: stall = id_valid & ((id_use_rn & hz(rn)) | (id_use_rm & hz(rm))) | (ex_hold & id_valid).
//   hz(s) = ex_valid & ex_memread & ex_regwrite & ex_rd==s & s!=ZERO_REG.
//   Exactly one bubble per load-use. The next cycle the load sits in MEM and is served by rule 3.
//  ID/EX register update priority at posedge:
//   1. reset -> reset values.
//   2. flush -> idex_valid<=0. Flush overrides ex_hold and the bubble.
//   3. ex_hold -> all idex_* hold their values.
//   4. load-use hazard -> idex_valid<=0 (bubble). op/rd/ctrl are don't-care; implement as hold.
//   5. Otherwise -> load id_* and resolved operands; idex_valid<=id_valid.
//  Latency: 1 cycle ID->EX. Throughput: 1 per cycle absent stalls.
//  stall_cycles increments on each cycle with stall=1 and saturates at 32'hFFFF_FFFF. Cleared only by reset.
//  Reset asserted mid-stall: the next cycle sees idex_valid=0 and stall_cycles=0.
// STRUCTURE
//  Package cpu_pipe_pkg holds DATA_W, ADDR_W, ZERO_REG constants and a fwd_sel_e enum {FWD_ZERO,FWD_EX,FWD_MEM,FWD_WB,FWD_RF}.
//  One sub-module: forward_mux. Instantiated twice (rn, rm). Combinational select per the priority above.
//  Exports fwd_sel_e for bench visibility.
//  ID/EX register, hazard detect and stall counter live in this module. The counter reuses registerEnabled.
// TESTING
//  1. No hazard: X1=0x11, X2=0x22 in regfile, ADD rn=1 rm=2 -> next cycle op_a=0x11, op_b=0x22, valid=1, stall never asserted.
//  2. EX/MEM/WB priority: ex, mem, wb all write X5 with 0xAA, 0xBB, 0xCC; ID reads rn=5 -> op_a=0xAA.
//     Drop ex -> 0xBB; drop mem -> 0xCC.
//  3. Load-use: LDUR X3 in EX (memread=1), ID reads rm=3 -> stall=1 one cycle, idex_valid=0.
//     Next cycle mem_result=0x1234 -> op_b=0x1234, stall_cycles=1.
//  4. XZR: ex_rd=31 writing 0xFF, ID reads rn=31 with ex_memread=1 -> op_a=0, stall=0.
//  5. Flush and hold: flush=1 together with ex_hold=1 -> idex_valid=0.
//     ex_hold alone for 3 cycles -> idex_* unchanged, stall=1, stall_cycles +3.
//  6. Reset mid-stall: assert reset during a load-use stall -> idex_valid=0, stall_cycles=0 the next cycle, stall=0 while reset is high.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants and the forwarding-source encoding used by the
// ID->EX operand stage and its bypass muxes.
package cpu_pipe_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(ZERO_REG);

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_sel_e;

endpackage

// File: rtl/forward_mux.sv
// Bypass selector for one source operand: XZR, then the youngest in-flight
// producer (EX, MEM, WB), then the register file.
module forward_mux
    import cpu_pipe_pkg::*;
(
    input  logic [ADDR_W-1:0] src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

    fwd_sel_e sel;

    // A load in EX has no data yet; that case is covered by the stall, not here.
    always_comb begin
        sel = FWD_RF;
        if (src == XZR)
            sel = FWD_ZERO;
        else if (ex_valid && ex_regwrite && !ex_memread && (ex_rd == src))
            sel = FWD_EX;
        else if (mem_valid && mem_regwrite && (mem_rd == src))
            sel = FWD_MEM;
        else if (wb_regwrite && (wb_rd == src))
            sel = FWD_WB;
    end

    always_comb begin
        operand = rf_data;
        case (sel)
            FWD_ZERO: operand = '0;
            FWD_EX:   operand = ex_result;
            FWD_MEM:  operand = mem_result;
            FWD_WB:   operand = wb_data;
            default:  operand = rf_data;
        endcase
    end

endmodule

// File: rtl/registerEnabled.sv
// Generic load-enabled register with synchronous active-high reset to zero.
module registerEnabled #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (enable)
            q <= d;
    end

endmodule

// File: rtl/operand_forward_stage.sv
// ID->EX operand stage: resolves RAW hazards by bypassing, stalls ID on
// load-use, and registers operands plus control into the ID/EX register.
module operand_forward_stage
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rn,
    input  logic [ADDR_W-1:0] id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [DATA_W-1:0] id_rn_data,
    input  logic [DATA_W-1:0] id_rm_data,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall,
    output logic              idex_valid,
    output logic [DATA_W-1:0] idex_op_a,
    output logic [DATA_W-1:0] idex_op_b,
    output logic [ADDR_W-1:0] idex_rd,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [31:0]       stall_cycles
);

    logic [DATA_W-1:0] op_a_fwd;
    logic [DATA_W-1:0] op_b_fwd;
    logic              hz_rn;
    logic              hz_rm;
    logic              load_use;
    logic              cnt_enable;
    logic [31:0]       cnt_next;

    forward_mux u_fwd_rn (
        .src          (id_rn),
        .rf_data      (id_rn_data),
        .ex_valid     (ex_valid),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .mem_valid    (mem_valid),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .operand      (op_a_fwd)
    );

    forward_mux u_fwd_rm (
        .src          (id_rm),
        .rf_data      (id_rm_data),
        .ex_valid     (ex_valid),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .mem_valid    (mem_valid),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .operand      (op_b_fwd)
    );

    // Only a load still in EX forces a bubble; one cycle later it is in MEM.
    always_comb begin
        hz_rn    = ex_valid && ex_memread && ex_regwrite && (ex_rd == id_rn) && (id_rn != XZR);
        hz_rm    = ex_valid && ex_memread && ex_regwrite && (ex_rd == id_rm) && (id_rm != XZR);
        load_use = id_valid && ((id_use_rn && hz_rn) || (id_use_rm && hz_rm));
        stall    = !reset && (load_use || (ex_hold && id_valid));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_valid <= 1'b0;
            idex_op_a  <= '0;
            idex_op_b  <= '0;
            idex_rd    <= '0;
            idex_ctrl  <= '0;
        end else if (flush) begin
            idex_valid <= 1'b0;
        end else if (ex_hold) begin
            idex_valid <= idex_valid;
        end else if (load_use) begin
            idex_valid <= 1'b0;
        end else begin
            idex_valid <= id_valid;
            idex_op_a  <= op_a_fwd;
            idex_op_b  <= op_b_fwd;
            idex_rd    <= id_rd;
            idex_ctrl  <= id_ctrl;
        end
    end

    assign cnt_enable = stall && (stall_cycles != 32'hFFFF_FFFF);
    assign cnt_next   = stall_cycles + 32'd1;

    registerEnabled #(.WIDTH(32)) u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .enable (cnt_enable),
        .d      (cnt_next),
        .q      (stall_cycles)
    );

endmodule
